mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. It grants one requester per transaction, with data priority and a starvation guard for fetch. It tracks the single outstanding transaction and routes the response back to its owner. It sits between the cpu core and a unified memory. The core uses the `*_valid` pulses to release its IF and MEM stall conditions.

## Interface
Parameters:
- `ADDR_W`, default 32, address width on all ports.
- `DATA_W`, default 32, read/write data width.
- `MAX_DATA_STREAK`, default 3, number of consecutive data grants allowed while fetch waits.

Ports:
- `clk`, in, 1, single clock. All state updates on its rising edge.
- `reset`, in, 1, synchronous, active-high.
- `if_req`, in, 1, fetch request. Held with `if_addr` stable until `if_gnt`.
- `if_addr`, in, ADDR_W, fetch address.
- `if_gnt`, out, 1, fetch request accepted by memory this cycle.
- `if_valid`, out, 1, one-cycle pulse: `if_rdata` holds the fetch result.
- `if_rdata`, out, DATA_W, fetch data.
- `d_req`, in, 1, data request. Held with all `d_*` inputs stable until `d_gnt`.
- `d_we`, in, 1, 1 = store, 0 = load.
- `d_addr`, in, ADDR_W, data address.
- `d_wdata`, in, DATA_W, store data.
- `d_size`, in, 3, xfer size code, passed through unchanged.
- `d_gnt`, out, 1, data request accepted this cycle.
- `d_valid`, out, 1, one-cycle pulse: load data ready, or store complete.
- `d_rdata`, out, DATA_W, load data.
- `m_req`, out, 1, memory request.
- `m_we`, out, 1, memory write enable.
- `m_addr`, out, ADDR_W, memory address.
- `m_wdata`, out, DATA_W, memory write data.
- `m_size`, out, 3, memory xfer size. Fetch always drives 3'b010 (word).
- `m_ready`, in, 1, memory accepts `m_req` this cycle.
- `m_rvalid`, in, 1, memory response for the outstanding transaction. Arrives at least 1 cycle after acceptance.
- `m_rdata`, in, DATA_W, memory read data.

## Operation
- States:
  - IDLE: no transaction outstanding.
  - BUSY: one accepted transaction outstanding. An `owner` register (IF or DATA) records whose it is.
- Arbitration:
  - It runs combinationally whenever the block is "free": state IDLE, or state BUSY with `m_rvalid` high this cycle.
  - Only one requester: that requester is selected.
  - Both requesting: DATA is selected unless `streak == MAX_DATA_STREAK`, in which case IF is selected.
- Selected requester drives `m_req` and the m_* fields. Fetch drives `m_we`=0 and `m_size`=3'b010.
- When `m_req && m_ready`:
  - Pulse the winner's `*_gnt`.
  - Latch `owner`.
  - Go to or stay in BUSY.
- Free and no accept: go to IDLE.
- `streak` counter:
  - Increments, saturating at `MAX_DATA_STREAK`, on a data grant while `if_req` is high.
  - Clears on any IF grant, or on a data grant with `if_req` low.
- Response routing:
  - `if_valid` = `m_rvalid && state==BUSY && owner==IF`.
  - `d_valid` = same condition with owner==DATA.
  - `if_rdata` and `d_rdata` both equal `m_rdata`.
- `m_rvalid` while IDLE is ignored: no valid pulse, no state change.
- When `m_req` is low, `m_we`, `m_addr`, `m_wdata` and `m_size` are driven 0.

## Timing
- Reset:
  - State IDLE, `owner` IF, `streak` 0.
  - All outputs 0 in the reset cycle, regardless of inputs.
- Grant path is Mealy: a request in a free cycle can be granted in the same cycle.
- Minimum turnaround is request cycle N, response cycle N+1, and the next grant is also in cycle N+1 (back-to-back).
- Simultaneous `m_rvalid` and a new accept:
  - The response is routed using the old `owner`.
  - The new `owner` takes effect next cycle.
- Reset while BUSY:
  - The outstanding transaction is abandoned.
  - A later `m_rvalid` for it is ignored, because the block is IDLE.
- A requester dropping `*_req` before grant is illegal. Behaviour is undefined; the bench checks it with an assertion.

## Structure
- Shared `cpu_pkg` holds:
  - `arb_state_e` (IDLE, BUSY).
  - `arb_owner_e` (OWN_IF, OWN_DATA).
  - `XFER_WORD` = 3'b010.
- One natural sub-module, `grant_picker`: purely combinational. It takes the free flag, both requests and the streak-limit flag, and produces the winner and grant enable.

## Test plan
- Fetch only: if_req=1, if_addr=0x100, m_ready=1, m_rvalid 2 cycles later with m_rdata=0xDEADBEEF → if_gnt in cycle 0, if_valid in cycle 2 with if_rdata=0xDEADBEEF, d_valid never asserts.
- Contention, MAX_DATA_STREAK=3: if_req and d_req held high, 1-cycle memory → grant order D, D, D, IF, D, D, D, IF; streak reads 0 after each IF grant.
- Back-to-back: m_rvalid and a new d_req in the same cycle → response goes to the old owner; d_gnt is asserted in that same cycle.
- Store: d_req=1, d_we=1, d_addr=0x10010, d_wdata=0xA5, d_size=0 → m_we=1, m_addr=0x10010, m_wdata=0xA5, m_size=0; d_valid pulses on m_rvalid.
- m_ready low for 4 cycles with d_req held → no d_gnt; m_* fields remain stable; d_gnt pulses on the first m_ready=1 cycle.
- reset asserted while BUSY, then m_rvalid=1 the cycle after reset → all outputs 0 during reset, no if_valid or d_valid pulse, state IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the memory port arbiter: FSM state, transaction owner and
// the fixed transfer size used by instruction fetch.
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

  localparam logic [2:0] XFER_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and unified memory port around the arbiter.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_size;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [2:0]        m_size;
  logic              m_ready;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size,
    input  m_ready, m_rvalid, m_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_size
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size,
    output m_ready, m_rvalid, m_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_size
  );

endinterface

// File: rtl/grant_picker.sv
// Combinational winner selection: data has priority unless fetch has already
// waited through the maximum data streak.
module grant_picker
  import cpu_pkg::*;
(
  input  logic       free_i,
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  logic       streak_max_i,
  output arb_owner_e winner_o,
  output logic       gnt_en_o
);

  // Pick the requester that may drive the memory port this cycle.
  always_comb begin
    winner_o = OWN_IF;
    gnt_en_o = 1'b0;
    if (free_i) begin
      gnt_en_o = if_req_i | d_req_i;
      if (d_req_i && !(if_req_i && streak_max_i)) begin
        winner_o = OWN_DATA;
      end else begin
        winner_o = OWN_IF;
      end
    end else begin
      gnt_en_o = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data port,
// tracking the single outstanding transaction and routing its response.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 2);

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;

  logic              free_s;
  logic              streak_max_s;
  logic              gnt_en_s;
  arb_owner_e        winner_s;
  logic              accept_s;
  logic              resp_s;
  logic              m_req_s;
  logic              m_we_s;
  logic [ADDR_W-1:0] m_addr_s;
  logic [DATA_W-1:0] m_wdata_s;
  logic [2:0]        m_size_s;

  // A response arriving this cycle frees the port for a back-to-back grant.
  assign free_s       = (state_q == IDLE) || bus.m_rvalid;
  assign streak_max_s = (streak_q == SW'(MAX_DATA_STREAK));

  grant_picker u_grant_picker (
    .free_i       (free_s),
    .if_req_i     (bus.if_req),
    .d_req_i      (bus.d_req),
    .streak_max_i (streak_max_s),
    .winner_o     (winner_s),
    .gnt_en_o     (gnt_en_s)
  );

  // Memory request mux; every field is forced to zero when no request is driven.
  always_comb begin
    m_req_s   = 1'b0;
    m_we_s    = 1'b0;
    m_addr_s  = '0;
    m_wdata_s = '0;
    m_size_s  = 3'b000;
    if (!reset && gnt_en_s) begin
      m_req_s = 1'b1;
      if (winner_s == OWN_DATA) begin
        m_we_s    = bus.d_we;
        m_addr_s  = bus.d_addr;
        m_wdata_s = bus.d_wdata;
        m_size_s  = bus.d_size;
      end else begin
        m_we_s    = 1'b0;
        m_addr_s  = bus.if_addr;
        m_wdata_s = '0;
        m_size_s  = XFER_WORD;
      end
    end else begin
      m_req_s = 1'b0;
    end
  end

  assign accept_s = m_req_s && bus.m_ready;
  assign resp_s   = !reset && bus.m_rvalid && (state_q == BUSY);

  assign bus.m_req    = m_req_s;
  assign bus.m_we     = m_we_s;
  assign bus.m_addr   = m_addr_s;
  assign bus.m_wdata  = m_wdata_s;
  assign bus.m_size   = m_size_s;
  assign bus.if_gnt   = accept_s && (winner_s == OWN_IF);
  assign bus.d_gnt    = accept_s && (winner_s == OWN_DATA);
  assign bus.if_valid = resp_s && (owner_q == OWN_IF);
  assign bus.d_valid  = resp_s && (owner_q == OWN_DATA);
  assign bus.if_rdata = reset ? '0 : bus.m_rdata;
  assign bus.d_rdata  = reset ? '0 : bus.m_rdata;

  // Next state, owner and streak; the response uses owner_q, the new owner lands next cycle.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    if (accept_s) begin
      state_d = BUSY;
      owner_d = winner_s;
      if (winner_s == OWN_DATA && bus.if_req) begin
        if (!streak_max_s) begin
          streak_d = streak_q + SW'(1);
        end else begin
          streak_d = streak_q;
        end
      end else begin
        streak_d = '0;
      end
    end else if (free_s) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset; reset abandons any outstanding transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: the bench plays core and memory,
// queueing the expected owner and data of each response when it issues the request.
module tb_mem_port_arbiter;
  import cpu_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic          is_data;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // A requester must hold its request until granted.
  a_if_hold: assert property (@(posedge clk) disable iff (reset)
    (!reset && bus.if_req && !bus.if_gnt) |=> (bus.if_req || reset))
    else $error("if_req dropped before grant");
  a_d_hold: assert property (@(posedge clk) disable iff (reset)
    (!reset && bus.d_req && !bus.d_gnt) |=> (bus.d_req || reset))
    else $error("d_req dropped before grant");

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.d_size   = 3'b000;
    bus.m_ready  = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
  endtask

  function automatic logic [166:0] all_outputs();
    return {bus.if_gnt, bus.if_valid, bus.if_rdata, bus.d_gnt, bus.d_valid, bus.d_rdata,
            bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_size};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'hFFFF_FFFF;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'hFFFF_FFFF;
    bus.d_wdata = 32'hFFFF_FFFF; bus.d_size = 3'b111;
    bus.m_ready = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_total++;
    if (all_outputs() !== '0) $display("FAIL reset_outputs: got %h want 0", all_outputs());
    else n_pass++;
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_total++;
    if (dut.state_q !== IDLE || dut.owner_q !== OWN_IF || dut.streak_q !== '0)
      $display("FAIL reset_state: state=%0d owner=%0d streak=%0d want 0/0/0",
               dut.state_q, dut.owner_q, dut.streak_q);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_fetch_only();
    exp_t e;
    bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.m_ready = 1'b1;
    sb.push_back({1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    n_total++;
    if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0 || bus.m_req !== 1'b1 || bus.m_addr !== 32'h100 ||
        bus.m_we !== 1'b0 || bus.m_size !== 3'b010 || bus.m_wdata !== '0)
      $display("FAIL fetch_grant: gnt=%b/%b req=%b addr=%h we=%b size=%b want 1/0 1 100 0 010",
               bus.if_gnt, bus.d_gnt, bus.m_req, bus.m_addr, bus.m_we, bus.m_size);
    else n_pass++;
    next_cycle();
    bus.if_req = 1'b0; bus.m_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0 || bus.m_req !== 1'b0)
      $display("FAIL fetch_wait: valid=%b/%b req=%b want 0/0 0", bus.if_valid, bus.d_valid, bus.m_req);
    else n_pass++;
    next_cycle();
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    if (bus.if_valid !== !e.is_data || bus.d_valid !== e.is_data || bus.if_rdata !== e.data)
      $display("FAIL fetch_resp: valid=%b/%b rdata=%h want %b/%b %h",
               bus.if_valid, bus.d_valid, bus.if_rdata, !e.is_data, e.is_data, e.data);
    else n_pass++;
    next_cycle();
    bus.m_rvalid = 1'b0;
    @(negedge clk);
    n_total++;
    if (dut.state_q !== IDLE) $display("FAIL fetch_idle: state=%0d want 0", dut.state_q);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_contention();
    logic exp_d [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_t e;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_size = 3'b010;
    bus.m_ready = 1'b1; bus.m_rvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h1000 + 32'(k - 1);
      end
      sb.push_back({exp_d[k], 32'h1000 + 32'(k)});
      @(negedge clk);
      if (k > 0) begin
        e = sb.pop_front();
        n_total++;
        if (bus.if_valid !== !e.is_data || bus.d_valid !== e.is_data ||
            (e.is_data ? bus.d_rdata : bus.if_rdata) !== e.data)
          $display("FAIL contention_resp%0d: valid=%b/%b rdata=%h want %b/%b %h", k,
                   bus.if_valid, bus.d_valid, bus.m_rdata, !e.is_data, e.is_data, e.data);
        else n_pass++;
      end
      n_total++;
      if (bus.if_gnt !== !exp_d[k] || bus.d_gnt !== exp_d[k] ||
          bus.m_addr !== (exp_d[k] ? 32'h300 : 32'h200))
        $display("FAIL contention_gnt%0d: if_gnt=%b d_gnt=%b addr=%h want %b %b", k,
                 bus.if_gnt, bus.d_gnt, bus.m_addr, !exp_d[k], exp_d[k]);
      else n_pass++;
      next_cycle();
      if (!exp_d[k]) begin
        n_total++;
        if (dut.streak_q !== '0) $display("FAIL contention_streak%0d: streak=%0d want 0", k, dut.streak_q);
        else n_pass++;
      end
    end
    bus.if_req = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1007;
    sb.push_back({1'b1, 32'h1008});
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== e.data || bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0)
      $display("FAIL contention_tail: if_valid=%b rdata=%h d_gnt=%b want 1 %h 1",
               bus.if_valid, bus.if_rdata, bus.d_gnt, e.data);
    else n_pass++;
    next_cycle();
    bus.d_req = 1'b0; bus.m_rdata = 32'h1008;
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    if (bus.d_valid !== 1'b1 || bus.if_valid !== 1'b0 || bus.d_rdata !== e.data ||
        bus.m_req !== 1'b0 || dut.streak_q !== '0)
      $display("FAIL contention_last: d_valid=%b rdata=%h req=%b streak=%0d want 1 %h 0 0",
               bus.d_valid, bus.d_rdata, bus.m_req, dut.streak_q, e.data);
    else n_pass++;
    next_cycle();
    bus.m_rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bus.if_req = 1'b1; bus.if_addr = 32'h400; bus.m_ready = 1'b1;
    sb.push_back({1'b0, 32'hCAFE_0001});
    @(negedge clk);
    n_total++;
    if (bus.if_gnt !== 1'b1) $display("FAIL b2b_if_gnt: got %b want 1", bus.if_gnt);
    else n_pass++;
    next_cycle();
    bus.if_req = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFE_0001;
    sb.push_back({1'b1, 32'hCAFE_0002});
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    if (bus.if_valid !== !e.is_data || bus.d_valid !== e.is_data || bus.if_rdata !== e.data ||
        bus.d_gnt !== 1'b1 || bus.m_addr !== 32'h500)
      $display("FAIL b2b_overlap: valid=%b/%b rdata=%h d_gnt=%b addr=%h want 1/0 %h 1 500",
               bus.if_valid, bus.d_valid, bus.if_rdata, bus.d_gnt, bus.m_addr, e.data);
    else n_pass++;
    next_cycle();
    bus.d_req = 1'b0; bus.m_rdata = 32'hCAFE_0002;
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    if (bus.d_valid !== e.is_data || bus.if_valid !== !e.is_data || bus.d_rdata !== e.data ||
        bus.m_req !== 1'b0)
      $display("FAIL b2b_second: valid=%b/%b rdata=%h req=%b want 0/1 %h 0",
               bus.if_valid, bus.d_valid, bus.d_rdata, bus.m_req, e.data);
    else n_pass++;
    next_cycle();
    bus.m_rvalid = 1'b0;
  endtask

  task automatic test_store();
    exp_t e;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1_0010; bus.d_wdata = 32'hA5;
    bus.d_size = 3'b000; bus.m_ready = 1'b1;
    sb.push_back({1'b1, 32'h0});
    @(negedge clk);
    n_total++;
    if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0 || bus.m_we !== 1'b1 || bus.m_addr !== 32'h1_0010 ||
        bus.m_wdata !== 32'hA5 || bus.m_size !== 3'b000)
      $display("FAIL store_req: gnt=%b we=%b addr=%h wdata=%h size=%b want 1 1 10010 a5 000",
               bus.d_gnt, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_size);
    else n_pass++;
    next_cycle();
    bus.d_req = 1'b0; bus.m_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.d_valid !== 1'b0 || bus.if_valid !== 1'b0)
      $display("FAIL store_wait: valid=%b/%b want 0/0", bus.if_valid, bus.d_valid);
    else n_pass++;
    next_cycle();
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0;
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    if (bus.d_valid !== e.is_data || bus.if_valid !== !e.is_data)
      $display("FAIL store_done: valid=%b/%b want 0/1", bus.if_valid, bus.d_valid);
    else n_pass++;
    next_cycle();
    bus.m_rvalid = 1'b0; bus.d_we = 1'b0;
  endtask

  task automatic test_stall();
    exp_t e;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'h5A5A;
    bus.d_size = 3'b001; bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (bus.d_gnt !== 1'b0 || bus.m_req !== 1'b1 || bus.m_we !== 1'b1 || bus.m_addr !== 32'h2000 ||
          bus.m_wdata !== 32'h5A5A || bus.m_size !== 3'b001)
        $display("FAIL stall%0d: gnt=%b req=%b we=%b addr=%h wdata=%h size=%b want 0 1 1 2000 5a5a 001",
                 i, bus.d_gnt, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_size);
      else n_pass++;
      next_cycle();
    end
    bus.m_ready = 1'b1;
    sb.push_back({1'b1, 32'h33});
    @(negedge clk);
    n_total++;
    if (bus.d_gnt !== 1'b1) $display("FAIL stall_release: gnt=%b want 1", bus.d_gnt);
    else n_pass++;
    next_cycle();
    bus.d_req = 1'b0; bus.m_ready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h33;
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    if (bus.d_valid !== e.is_data || bus.d_rdata !== e.data)
      $display("FAIL stall_resp: valid=%b rdata=%h want 1 %h", bus.d_valid, bus.d_rdata, e.data);
    else n_pass++;
    next_cycle();
    bus.m_rvalid = 1'b0; bus.d_we = 1'b0;
  endtask

  task automatic test_reset_busy();
    bus.if_req = 1'b1; bus.if_addr = 32'h600; bus.m_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.if_gnt !== 1'b1) $display("FAIL rbusy_gnt: got %b want 1", bus.if_gnt);
    else n_pass++;
    next_cycle();
    reset = 1'b1;
    bus.d_req = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h99;
    @(negedge clk);
    n_total++;
    if (all_outputs() !== '0) $display("FAIL rbusy_outputs: got %h want 0", all_outputs());
    else n_pass++;
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h99;
    @(negedge clk);
    n_total++;
    if (dut.state_q !== IDLE || bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0 || bus.m_req !== 1'b0)
      $display("FAIL rbusy_stale: state=%0d valid=%b/%b req=%b want 0 0/0 0",
               dut.state_q, bus.if_valid, bus.d_valid, bus.m_req);
    else n_pass++;
    next_cycle();
    bus.m_rvalid = 1'b0;
    @(negedge clk);
    n_total++;
    if (dut.state_q !== IDLE) $display("FAIL rbusy_idle: state=%0d want 0", dut.state_q);
    else n_pass++;
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_contention();
    test_back_to_back();
    test_store();
    test_stall();
    test_reset_busy();
    n_total++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
